// File: rtl/pipe_pkg.sv
// Shared types and constants for the pipeline hazard controller: tracked-stage
// record, forwarding select codes and the memory-wait FSM state.
package pipe_pkg;

    localparam int unsigned REG_W  = 5;
    localparam int unsigned STAGES = 3;

    localparam int unsigned ST_EX  = 0;
    localparam int unsigned ST_MEM = 1;
    localparam int unsigned ST_WB  = 2;

    localparam logic [1:0] FWD_RF    = 2'd0;
    localparam logic [1:0] FWD_EXMEM = 2'd1;
    localparam logic [1:0] FWD_MEMWB = 2'd2;

    typedef enum logic {
        IDLE,
        WAIT
    } mem_state_e;

    typedef struct packed {
        logic             v;
        logic             wr;
        logic [REG_W-1:0] rd;
        logic             ld;
        logic             mem;
    } dest_t;

    localparam dest_t DEST_EMPTY = '0;

    // MEM (younger) beats WB; a load sitting in MEM has no data to forward yet.
    function automatic logic [1:0] fwd_select(
        input dest_t            mem_st,
        input dest_t            wb_st,
        input logic             use_en,
        input logic [REG_W-1:0] src
    );
        logic [1:0] sel;
        sel = FWD_RF;
        if (mem_st.v && mem_st.wr && !mem_st.ld && use_en && (src == mem_st.rd)) begin
            sel = FWD_EXMEM;
        end else if (wb_st.v && wb_st.wr && use_en && (src == wb_st.rd)) begin
            sel = FWD_MEMWB;
        end
        return sel;
    endfunction

endpackage

// File: rtl/pipe_dest_tracker.sv
// Three-deep shadow of in-flight destinations (EX, MEM, WB) with freeze and
// bubble-injection control; shared by hazard and future flush logic.
module pipe_dest_tracker
    import pipe_pkg::*;
(
    input  logic  clk,
    input  logic  rst,
    input  logic  i_freeze,
    input  logic  i_bubble,
    input  dest_t i_id,
    output dest_t o_stage [STAGES]
);

    dest_t r_stage [STAGES];
    dest_t w_ex_in;

    always_comb begin
        w_ex_in = i_id;
        if (i_bubble || !i_id.v) begin
            w_ex_in = DEST_EMPTY;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int s = 0; s < int'(STAGES); s++) begin
                r_stage[s] <= DEST_EMPTY;
            end
        end else if (!i_freeze) begin
            r_stage[ST_EX] <= w_ex_in;
            for (int s = 1; s < int'(STAGES); s++) begin
                r_stage[s] <= r_stage[s-1];
            end
        end
    end

    assign o_stage = r_stage;

endmodule

// File: rtl/pipe_hazard_ctrl.sv
// Pipeline sequencing: load-use stall/bubble, ALU operand forwarding selects
// and a memory-wait FSM that freezes the pipeline until the RAM acknowledges.
module pipe_hazard_ctrl
    import pipe_pkg::*;
(
    input  logic             clk,
    input  logic             rst,
    input  logic             id_valid,
    input  logic [REG_W-1:0] id_src0,
    input  logic [REG_W-1:0] id_src1,
    input  logic             id_use0,
    input  logic             id_use1,
    input  logic             id_write,
    input  logic [REG_W-1:0] id_writeReg,
    input  logic             id_ReadMem,
    input  logic             id_WriteMem,
    input  logic             mem_ready,
    output logic             stall_if,
    output logic             stall_id,
    output logic             bubble_ex,
    output logic             freeze,
    output logic [1:0]       fwd_sel0,
    output logic [1:0]       fwd_sel1,
    output logic             mem_busy
);

    mem_state_e r_state;
    mem_state_e w_state_next;
    dest_t      w_id;
    dest_t      w_stage [STAGES];
    dest_t      w_ex;
    dest_t      w_mem;
    dest_t      w_wb;
    logic       w_hz;
    logic       w_freeze;
    logic       w_mem_req;

    always_comb begin
        w_id.v   = id_valid;
        w_id.wr  = id_valid & id_write;
        w_id.rd  = id_writeReg;
        w_id.ld  = id_valid & id_ReadMem;
        w_id.mem = id_valid & (id_ReadMem | id_WriteMem);
    end

    pipe_dest_tracker u_tracker (
        .clk      (clk),
        .rst      (rst),
        .i_freeze (w_freeze),
        .i_bubble (bubble_ex),
        .i_id     (w_id),
        .o_stage  (w_stage)
    );

    assign w_ex  = w_stage[ST_EX];
    assign w_mem = w_stage[ST_MEM];
    assign w_wb  = w_stage[ST_WB];

    assign w_hz = id_valid & w_ex.v & w_ex.wr & w_ex.ld &
                  ((id_use0 & (id_src0 == w_ex.rd)) | (id_use1 & (id_src1 == w_ex.rd)));

    assign w_mem_req = w_mem.v & w_mem.mem;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    // Freeze is raised combinationally on the first unready cycle, not a cycle later.
    always_comb begin
        w_state_next = r_state;
        w_freeze     = 1'b0;
        unique case (r_state)
            IDLE: begin
                if (w_mem_req && !mem_ready) begin
                    w_state_next = WAIT;
                    w_freeze     = 1'b1;
                end
            end
            WAIT: begin
                if (mem_ready) begin
                    w_state_next = IDLE;
                end else begin
                    w_freeze = 1'b1;
                end
            end
        endcase
    end

    assign freeze    = w_freeze;
    assign stall_if  = w_freeze | w_hz;
    assign stall_id  = w_freeze | w_hz;
    assign bubble_ex = w_hz & ~w_freeze;
    assign mem_busy  = (r_state == WAIT);

    assign fwd_sel0 = fwd_select(w_mem, w_wb, id_use0, id_src0);
    assign fwd_sel1 = fwd_select(w_mem, w_wb, id_use1, id_src1);

endmodule
